// File: rtl/sad_stream_acc.sv
// sad_stream_acc: streaming sum-of-absolute-differences accumulator.
// Each accepted beat carries LANES pixel pairs. Stage 1 registers the
// per-lane |a-b|, already truncated when the block runs in approximate
// mode. Stage 2 folds the lane sum into the block accumulator and loads
// the result register on the last beat of each block.
module sad_stream_acc #(
  parameter int W          = 8,
  parameter int LANES      = 4,
  parameter int BEATS      = 4,
  parameter int APPROX_LSB = 2,
  parameter int SAD_W      = W + $clog2(LANES * BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic               approx_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SAD_W-1:0]   out_sad,
  output logic               out_approx
);

  localparam int LSUM_W = W + $clog2(LANES);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [W-1:0]     AMASK    = {W{1'b1}} << APPROX_LSB;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic               stall;
  logic               accept;
  logic               blk_mode;
  logic               beat_last;
  logic [LANES*W-1:0] diff_next;
  logic [LSUM_W-1:0]  lane_sum;
  logic [SAD_W-1:0]   acc_sum;

  logic [CNT_W-1:0]   cnt_reg;
  logic               mode_reg;
  logic               s1_valid_reg;
  logic               s1_last_reg;
  logic               s1_mode_reg;
  logic [LANES*W-1:0] s1_diff_reg;
  logic [SAD_W-1:0]   acc_reg;
  logic               out_valid_reg;
  logic [SAD_W-1:0]   out_sad_reg;
  logic               out_approx_reg;

  assign stall     = out_valid_reg & ~out_ready;
  assign in_ready  = ~stall & ~flush;
  assign accept    = in_valid & in_ready;
  // The first beat of a block takes its mode straight from approx_en;
  // later beats reuse the mode latched on that first beat.
  assign blk_mode  = (cnt_reg == '0) ? approx_en : mode_reg;
  assign beat_last = (cnt_reg == LAST_CNT);

  // Per-lane absolute difference, truncated in approximate mode.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0] a_l;
      logic [W-1:0] b_l;
      logic [W-1:0] d_l;
      assign a_l = in_a[gi*W +: W];
      assign b_l = in_b[gi*W +: W];
      assign d_l = (a_l >= b_l) ? (a_l - b_l) : (b_l - a_l);
      assign diff_next[gi*W +: W] = blk_mode ? (d_l & AMASK) : d_l;
    end
  endgenerate

  // Sum of the registered lane differences (width sized so it cannot wrap).
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + LSUM_W'(s1_diff_reg[i*W +: W]);
    end
  end

  assign acc_sum = acc_reg + SAD_W'(lane_sum);

  // Stage 1 and beat counter: capture accepted beats, hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      mode_reg     <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_diff_reg  <= '0;
    end else if (flush) begin
      cnt_reg      <= '0;
      s1_valid_reg <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_diff_reg <= diff_next;
        s1_last_reg <= beat_last;
        s1_mode_reg <= blk_mode;
        cnt_reg     <= beat_last ? '0 : cnt_reg + 1'b1;
        if (cnt_reg == '0) begin
          mode_reg <= approx_en;
        end
      end
    end
  end

  // Stage 2 and output register: accumulate, emit on last beat, retire on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_sad_reg    <= '0;
      out_approx_reg <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (flush) begin
        acc_reg <= '0;
      end else if (s1_valid_reg && !stall) begin
        if (s1_last_reg) begin
          out_sad_reg    <= acc_sum;
          out_approx_reg <= s1_mode_reg;
          out_valid_reg  <= 1'b1;
          acc_reg        <= '0;
        end else begin
          acc_reg <= acc_sum;
        end
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_sad    = out_sad_reg;
  assign out_approx = out_approx_reg;

endmodule

// File: tb/tb_sad_stream_acc.sv
// Testbench for sad_stream_acc: directed scenarios followed by randomized
// traffic, all results compared against a block-level reference model.
module tb_sad_stream_acc;

  localparam int W          = 8;
  localparam int LANES      = 4;
  localparam int BEATS      = 4;
  localparam int APPROX_LSB = 2;
  localparam int SAD_W      = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic               approx_en;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [SAD_W-1:0]   out_sad;
  logic               out_approx;

  sad_stream_acc #(
    .W(W), .LANES(LANES), .BEATS(BEATS), .APPROX_LSB(APPROX_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .approx_en(approx_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_approx(out_approx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: block-level sums of (optionally truncated) differences.
  int exp_sad_q[$];
  bit exp_mode_q[$];
  int part_sum  = 0;
  int part_cnt  = 0;
  bit part_mode = 0;

  function automatic int beat_sad(input logic [31:0] a, input logic [31:0] b, input bit m);
    int s;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      int av, bv, d;
      av = int'(a[i*W +: W]);
      bv = int'(b[i*W +: W]);
      d  = (av > bv) ? av - bv : bv - av;
      if (m) d = d - (d % (1 << APPROX_LSB));
      s += d;
    end
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  // Observations from the most recent cycle.
  bit              acc_flag   = 0;
  bit              ov_seen    = 0;
  int              got_sad    = -1;
  bit              got_mode   = 0;
  int              n_out      = 0;
  bit              hold_prev  = 0;
  logic [SAD_W-1:0] held_sad  = '0;
  bit              held_mode  = 0;
  bit              last_in_s1 = 0;

  task automatic model_reset();
    exp_sad_q.delete();
    exp_mode_q.delete();
    part_sum   = 0;
    part_cnt   = 0;
    part_mode  = 0;
    hold_prev  = 0;
    last_in_s1 = 0;
  endtask

  // One clock cycle: sample at the falling edge, update the model, step.
  task automatic cycle();
    bit stall, rdy, is_last;
    int e;
    bit m;
    @(negedge clk);
    stall = out_valid && !out_ready;
    rdy   = !stall && !flush;
    check("in_ready", in_ready, rdy);
    ov_seen = out_valid;
    if (stall && hold_prev) begin
      check("hold_sad", out_sad, held_sad);
      check("hold_approx", out_approx, held_mode);
    end
    hold_prev = stall;
    held_sad  = out_sad;
    held_mode = out_approx;
    if (out_valid && out_ready) begin
      if (exp_sad_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_sad_q.pop_front();
        m = exp_mode_q.pop_front();
        check("out_sad", out_sad, e);
        check("out_approx", out_approx, m);
      end
      got_sad  = int'(out_sad);
      got_mode = out_approx;
      n_out++;
      $display("OUT #%0d sad=%0d approx=%0d", n_out, out_sad, out_approx);
    end
    acc_flag = in_valid && rdy;
    is_last  = 0;
    if (flush) begin
      part_sum = 0;
      part_cnt = 0;
    end else if (acc_flag) begin
      if (part_cnt == 0) part_mode = approx_en;
      part_sum += beat_sad(in_a, in_b, part_mode);
      part_cnt++;
      if (part_cnt == BEATS) begin
        is_last = 1;
        exp_sad_q.push_back(part_sum);
        exp_mode_q.push_back(part_mode);
        part_sum = 0;
        part_cnt = 0;
      end
    end
    if (flush) last_in_s1 = 0;
    else if (!stall) last_in_s1 = acc_flag && is_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit m);
    bit done;
    done      = 0;
    in_valid  = 1;
    in_a      = a;
    in_b      = b;
    approx_en = m;
    for (int t = 0; t < 50 && !done; t++) begin
      cycle();
      done = acc_flag;
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic send_block(input logic [7:0] a, input logic [7:0] b, input bit m);
    for (int i = 0; i < BEATS; i++) send_beat(lanes(a), lanes(b), m);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) cycle();
  endtask

  int n_before;

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 1; approx_en = 0;
    in_a = '0; in_b = '0;
    model_reset();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sad", out_sad, 0);
    check("rst_out_approx", out_approx, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Maximum value and latency
    send_block(8'd255, 8'd0, 0);
    in_valid = 0;
    cycle(); check("max_lat_early", ov_seen, 0);
    cycle(); check("max_lat_valid", ov_seen, 1);
    check("max_sad", got_sad, 4080); check("max_approx", got_mode, 0);
    cycle(); check("max_one_cycle", ov_seen, 0);

    // Exact vs approximate
    send_block(8'd3, 8'd10, 0); idle(3);
    check("exact_sad", got_sad, 112); check("exact_mode", got_mode, 0);
    send_block(8'd3, 8'd10, 1); idle(3);
    check("approx_sad", got_sad, 64); check("approx_mode", got_mode, 1);

    // Mode latched on the first beat only
    send_beat(lanes(8'd0), lanes(8'd7), 1);
    for (int i = 1; i < BEATS; i++) send_beat(lanes(8'd0), lanes(8'd7), 0);
    idle(3);
    check("latch_sad", got_sad, 64); check("latch_mode", got_mode, 1);

    // Backpressure
    out_ready = 0;
    n_before = n_out;
    send_block(8'd1, 8'd0, 0);
    send_beat(lanes(8'd2), lanes(8'd0), 0);
    in_valid = 1;
    repeat (4) begin
      cycle();
      check("bp_stalled", acc_flag, 0);
      check("bp_held_valid", ov_seen, 1);
    end
    check("bp_no_early_out", n_out, n_before);
    out_ready = 1;
    send_beat(lanes(8'd2), lanes(8'd0), 0);
    check("bp_first", got_sad, 16);
    send_beat(lanes(8'd2), lanes(8'd0), 0);
    send_beat(lanes(8'd2), lanes(8'd0), 0);
    idle(3);
    check("bp_second", got_sad, 32);
    check("bp_count", n_out, n_before + 2);

    // Flush drops the partial block and the beat presented with it
    send_beat(lanes(8'd9), lanes(8'd0), 0);
    send_beat(lanes(8'd9), lanes(8'd0), 0);
    flush = 1; in_valid = 1; in_a = lanes(8'd9);
    cycle();
    check("flush_dropped", acc_flag, 0);
    flush = 0;
    send_block(8'd1, 8'd0, 0); idle(3);
    check("flush_sad", got_sad, 16);

    // Reset mid-block with a pending result
    out_ready = 0;
    send_block(8'd5, 8'd0, 0);
    send_beat(lanes(8'd5), lanes(8'd0), 0);
    in_valid = 0;
    cycle();
    check("rst_pending", ov_seen, 1);
    rst_n = 0;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sad", out_sad, 0);
    check("mid_rst_approx", out_approx, 0);
    check("mid_rst_ready", in_ready, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    n_before = n_out;
    send_block(8'd1, 8'd0, 0); idle(3);
    check("post_rst_sad", got_sad, 16);
    check("post_rst_count", n_out, n_before + 1);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      in_valid  = ($urandom % 4) != 0;
      in_a      = $urandom;
      in_b      = $urandom;
      approx_en = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      flush     = !last_in_s1 && (($urandom % 40) == 0);
      cycle();
    end
    flush = 0; out_ready = 1;
    idle(10);
    check("drain_empty", exp_sad_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
